load_hazard_scoreboard: RTL and testbench
=========================================

Name: load_hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-stage load-to-use check: tracks every in-flight load destination in a per-register pending scoreboard, so loads may take any number of cycles to return.
- Sits beside the decode/issue stage.
- Stalls issue on RAW (source pending) and WAW (destination pending) hazards, and caps the number of outstanding loads.
- Flush drops all pending state.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never pending.
- AW, 5, register address width; requires 2**AW >= NREG.
- NRD, 2, number of source read ports checked per issued instruction.
- MAX_PEND, 4, maximum outstanding loads; legal range 1..NREG-1.
- CW, 3, width of the outstanding counter; requires 2**CW > MAX_PEND.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- iss_valid  in  1  issue stage holds a valid instruction.
- iss_src  in  NRD*AW  source register addresses; port k is bits [k*AW +: AW].
- iss_src_en  in  NRD  per-port "source actually read" mask.
- iss_load  in  1  instruction is a load writing iss_dest.
- iss_dest  in  AW  load destination register.
- iss_fire  out  1  iss_valid & ~stall; the instruction leaves issue this cycle.
- stall  out  1  hold the issue stage.
- wb_valid  in  1  a load result is written back this cycle.
- wb_dest  in  AW  register written by that load.
- flush  in  1  pipeline flush; all in-flight loads are discarded upstream.
- pend_cnt  out  CW  registered count of outstanding loads.
- pend_vec  out  NREG  registered scoreboard (bit r = register r pending).

Behaviour:
- Reset (resetn=0, asynchronous): pend_vec=0 and pend_cnt=0. With iss_valid=0 during reset, stall=0 and iss_fire=0.
- Same-cycle writeback release: wb_data is forwarded, so a register r counts as busy this cycle iff pend_vec[r] & ~(wb_valid & wb_dest==r).
- RAW hazard: for any enabled port k, iss_src[k]!=0 and busy(iss_src[k]).
- WAW hazard: iss_load & iss_dest!=0 & busy(iss_dest).
- Capacity hazard: iss_load & (pend_cnt - (wb_valid ? 1 : 0)) == MAX_PEND.
- stall = iss_valid & ~flush & (RAW | WAW | capacity). It is purely combinational, with zero cycles of latency.
- Set: iss_fire & iss_load & iss_dest!=0 sets pend_vec[iss_dest] at the next edge. A load to r0 fires but is not tracked or counted.
- Clear: wb_valid clears pend_vec[wb_dest] at the next edge.
- Set and clear on the same register in the same cycle: set wins, and the counter nets to zero. This case arises only when a writeback releases a WAW stall.
- pend_cnt update: +1 on a tracked set, -1 on a clear of a pending bit, unchanged when both occur.
- wb_valid to a non-pending register, or to r0, is ignored. The counter does not change. It is flagged as an error in simulation only.
- flush (synchronous, highest priority): pend_vec=0 and pend_cnt=0 at the next edge. Same-cycle set and clear are ignored, and stall=0 that cycle. Writebacks for flushed loads are suppressed upstream.
- Invariant: pend_cnt == popcount(pend_vec) at all times. Overflow is impossible by construction.

Optional Feature:
- Macro: LOAD_HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_raw_cyc, perf_waw_cyc and perf_cap_cyc, each 32 bits.
  - Each counts cycles in which stall=1 attributable to that cause, with priority RAW > WAW > capacity.
  - Counters saturate at 0xFFFFFFFF, reset to 0, and are not cleared by flush.
- When undefined: the ports are absent and there is no counter logic.

Decomposition:
- Shared package lhs_pkg holds:
  - Default constants for NREG, AW and MAX_PEND.
  - A hazard-cause enum {HZ_NONE, HZ_RAW, HZ_WAW, HZ_CAP} for perf attribution and debug.
- One natural sub-module: lhs_src_check, instantiated NRD times. It takes one source address, its enable, pend_vec, wb_valid and wb_dest, and returns that port's RAW hit.

Test Plan:
- Basic RAW: fire a load to r5, then issue a reader with src0=r5 and wb_valid=0. Expect stall=1, pend_vec[5]=1 and pend_cnt=1. Then assert wb_valid with wb_dest=5. Expect stall=0 and iss_fire=1 that same cycle, with pend_vec[5]=0 and pend_cnt=0 after the edge.
- r0 and masking: load to r0 leaves pend_vec=0 and pend_cnt=0. A reader with src1=r7 and iss_src_en=2'b01 while r7 is pending gives stall=0.
- WAW with set-wins: with r3 pending, issue a load to r3. Expect stall=1. In the cycle wb_dest=3 arrives, expect iss_fire=1, pend_vec[3]=1 after the edge, and pend_cnt unchanged at 1.
- Capacity (MAX_PEND=4): fire loads to r1..r4, giving pend_cnt=4. A fifth load to r9 stalls. Asserting wb_valid with wb_dest=1 in the same cycle lets it fire, leaving pend_cnt=4 with pend_vec bits {2,3,4,9} set.
- Flush: with 3 loads pending and a stalled reader, assert flush. Expect stall=0 that cycle, and pend_vec=0 and pend_cnt=0 next cycle. A concurrent issue of a load to r6 is not recorded.
- Async reset mid-operation: deassert resetn between edges with pend_cnt=2. pend_vec and pend_cnt go to 0 immediately, and stall is low during reset.

Source files
------------

// File: rtl/lhs_pkg.sv
// Shared constants and types for the load hazard scoreboard.
package lhs_pkg;

  localparam int LHS_NREG     = 32;
  localparam int LHS_AW       = 5;
  localparam int LHS_MAX_PEND = 4;
  localparam int LHS_CW       = 3;

  // Reason an issue stall was raised; used for perf attribution and debug.
  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_RAW  = 2'd1,
    HZ_WAW  = 2'd2,
    HZ_CAP  = 2'd3
  } hz_cause_e;

endpackage

// File: rtl/lhs_src_check.sv
// One source-port RAW check against the pending-load scoreboard.
// A writeback landing this cycle is forwarded, so it releases its register.
module lhs_src_check
  import lhs_pkg::*;
#(
  parameter int NREG = LHS_NREG,
  parameter int AW   = LHS_AW
) (
  input  logic [AW-1:0]   src,
  input  logic            src_en,
  input  logic [NREG-1:0] pend_vec,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_dest,
  output logic            raw_hit
);

  logic pend_hit;

  // Scoreboard lookup; addresses beyond NREG never match
  always_comb begin
    pend_hit = 1'b0;
    for (int r = 0; r < NREG; r++)
      if (src == AW'(r)) pend_hit = pend_vec[r];
  end

  assign raw_hit = src_en & (src != '0) & pend_hit & ~(wb_valid & (wb_dest == src));

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Per-register pending-load scoreboard beside decode/issue. Stalls issue on
// RAW, WAW and outstanding-load capacity hazards; flush drops all state.
// Optional build macro LOAD_HAZARD_PERF_EN adds saturating stall-cause
// cycle counters (RAW > WAW > capacity attribution).
module load_hazard_scoreboard
  import lhs_pkg::*;
#(
  parameter int NREG     = LHS_NREG,
  parameter int AW       = LHS_AW,
  parameter int NRD      = 2,
  parameter int MAX_PEND = LHS_MAX_PEND,
  parameter int CW       = LHS_CW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iss_valid,
  input  logic [NRD*AW-1:0] iss_src,
  input  logic [NRD-1:0]    iss_src_en,
  input  logic              iss_load,
  input  logic [AW-1:0]     iss_dest,
  output logic              iss_fire,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_dest,
  input  logic              flush,
  output logic [CW-1:0]     pend_cnt,
  output logic [NREG-1:0]   pend_vec
`ifdef LOAD_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_raw_cyc,
  output logic [31:0]       perf_waw_cyc,
  output logic [31:0]       perf_cap_cyc
`endif
);

  logic [NRD-1:0]  raw_hit;
  logic            raw, waw, cap;
  logic            dest_pend, wb_hit;
  logic            set_en, clr_en;
  logic [CW-1:0]   cnt_eff;
  logic [NREG-1:0] vec_nxt;
  logic [CW-1:0]   cnt_nxt;

  for (genvar k = 0; k < NRD; k++) begin : g_src
    lhs_src_check #(.NREG(NREG), .AW(AW)) u_src (
      .src      (iss_src[k*AW +: AW]),
      .src_en   (iss_src_en[k]),
      .pend_vec (pend_vec),
      .wb_valid (wb_valid),
      .wb_dest  (wb_dest),
      .raw_hit  (raw_hit[k])
    );
  end

  // Scoreboard lookups for the load destination and the writeback register
  always_comb begin
    dest_pend = 1'b0;
    wb_hit    = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (iss_dest == AW'(r)) dest_pend = pend_vec[r];
      if (wb_dest  == AW'(r)) wb_hit    = pend_vec[r];
    end
  end

  // A writeback this cycle frees its slot before the capacity test
  assign cnt_eff = pend_cnt - CW'(wb_valid);
  assign raw     = |raw_hit;
  assign waw     = iss_load & (iss_dest != '0) & dest_pend & ~(wb_valid & (wb_dest == iss_dest));
  assign cap     = iss_load & (cnt_eff == CW'(MAX_PEND));
  assign stall    = iss_valid & ~flush & (raw | waw | cap);
  assign iss_fire = iss_valid & ~stall;

  assign set_en = iss_fire & iss_load & (iss_dest != '0);
  assign clr_en = wb_valid & wb_hit;

  // Next scoreboard: clear first so a same-register set wins
  always_comb begin
    vec_nxt = pend_vec;
    for (int r = 1; r < NREG; r++) begin
      if (clr_en && wb_dest  == AW'(r)) vec_nxt[r] = 1'b0;
      if (set_en && iss_dest == AW'(r)) vec_nxt[r] = 1'b1;
    end
    case ({set_en, clr_en})
      2'b10:   cnt_nxt = pend_cnt + 1'b1;
      2'b01:   cnt_nxt = pend_cnt - 1'b1;
      default: cnt_nxt = pend_cnt;
    endcase
  end

  // Scoreboard state; flush overrides any same-cycle set or clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_vec <= '0;
      pend_cnt <= '0;
    end else if (flush) begin
      pend_vec <= '0;
      pend_cnt <= '0;
    end else begin
      pend_vec <= vec_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

`ifndef SYNTHESIS
  // A writeback that frees nothing means upstream tracking is out of step
  always @(posedge clk)
    if (resetn && !flush && wb_valid && !wb_hit)
      $error("load_hazard_scoreboard: writeback to non-pending r%0d", wb_dest);
`endif

`ifdef LOAD_HAZARD_PERF_EN
  hz_cause_e cause;

  // Attribute each stall cycle to exactly one cause
  always_comb begin
    cause = HZ_NONE;
    if (stall) begin
      if (raw)      cause = HZ_RAW;
      else if (waw) cause = HZ_WAW;
      else          cause = HZ_CAP;
    end
  end

  // Saturating cause counters; survive flush, cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_raw_cyc <= '0;
      perf_waw_cyc <= '0;
      perf_cap_cyc <= '0;
    end else begin
      if (cause == HZ_RAW && perf_raw_cyc != '1) perf_raw_cyc <= perf_raw_cyc + 1'b1;
      if (cause == HZ_WAW && perf_waw_cyc != '1) perf_waw_cyc <= perf_waw_cyc + 1'b1;
      if (cause == HZ_CAP && perf_cap_cyc != '1) perf_cap_cyc <= perf_cap_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: directed scenarios plus random traffic
// checked against a set-of-pending-registers reference model.
module tb_load_hazard_scoreboard;
  localparam int NREG = 32, AW = 5, NRD = 2, MAX_PEND = 4, CW = 3;

  logic              clk = 1'b0, resetn;
  logic              iss_valid, iss_load, wb_valid, flush;
  logic [NRD*AW-1:0] iss_src;
  logic [NRD-1:0]    iss_src_en;
  logic [AW-1:0]     iss_dest, wb_dest;
  logic              iss_fire, stall;
  logic [CW-1:0]     pend_cnt;
  logic [NREG-1:0]   pend_vec;

  int n_cmp = 0, n_bad = 0;
  bit mpend [NREG];

  load_hazard_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .MAX_PEND(MAX_PEND), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .iss_valid(iss_valid), .iss_src(iss_src),
    .iss_src_en(iss_src_en), .iss_load(iss_load), .iss_dest(iss_dest),
    .iss_fire(iss_fire), .stall(stall), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .flush(flush), .pend_cnt(pend_cnt), .pend_vec(pend_vec)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(mpend[r]);
    return n;
  endfunction

  function automatic logic [NREG-1:0] m_vec();
    logic [NREG-1:0] v = '0;
    for (int r = 0; r < NREG; r++) v[r] = mpend[r];
    return v;
  endfunction

  function automatic bit m_busy(int r);
    return r != 0 && mpend[r] && !(wb_valid && int'(wb_dest) == r);
  endfunction

  function automatic bit m_stall();
    bit raw = 0, waw, cap;
    for (int k = 0; k < NRD; k++)
      if (iss_src_en[k] && m_busy(int'(iss_src[k*AW +: AW]))) raw = 1;
    waw = iss_load && m_busy(int'(iss_dest));
    cap = iss_load && (m_count() - (wb_valid ? 1 : 0)) == MAX_PEND;
    return iss_valid && !flush && (raw || waw || cap);
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREG; r++) mpend[r] = 0;
  endtask

  // Advance one clock, applying the spec rules to the model first
  task automatic go();
    bit fire = iss_valid && !m_stall();
    if (flush) m_clear();
    else begin
      if (wb_valid && wb_dest != 0) mpend[wb_dest] = 0;
      if (fire && iss_load && iss_dest != 0) mpend[iss_dest] = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input bit ld, input int dest, input int s0, input int s1,
                       input logic [1:0] en, input bit wbv, input int wbd, input bit fl);
    iss_valid = v; iss_load = ld; iss_dest = AW'(dest);
    iss_src = {AW'(s1), AW'(s0)}; iss_src_en = en;
    wb_valid = wbv; wb_dest = AW'(wbd); flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); resetn = 1'b0; m_clear();
    #3;
    n_cmp++; if (pend_vec !== '0) begin n_bad++; $display("FAIL reset_vec: got %h want 0", pend_vec); end
    n_cmp++; if (pend_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", pend_cnt); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (iss_fire !== 1'b0) begin n_bad++; $display("FAIL reset_fire: got %b want 0", iss_fire); end
    #9 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_raw();
    drive(1, 1, 5, 0, 0, 2'b00, 0, 0, 0); #4;
    n_cmp++; if (iss_fire !== 1'b1) begin n_bad++; $display("FAIL raw_load_fire: got %b want 1", iss_fire); end
    go();
    drive(1, 0, 0, 5, 0, 2'b01, 0, 0, 0); #4;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall: got %b want 1", stall); end
    n_cmp++; if (pend_vec !== 32'h20 || pend_cnt !== 3'd1) begin n_bad++; $display("FAIL raw_pend: got %h/%0d want 20/1", pend_vec, pend_cnt); end
    go();
    drive(1, 0, 0, 5, 0, 2'b01, 1, 5, 0); #4;
    n_cmp++; if (stall !== 1'b0 || iss_fire !== 1'b1) begin n_bad++; $display("FAIL raw_release: got stall=%b fire=%b want 0/1", stall, iss_fire); end
    go();
    n_cmp++; if (pend_vec !== '0 || pend_cnt !== 3'd0) begin n_bad++; $display("FAIL raw_after_wb: got %h/%0d want 0/0", pend_vec, pend_cnt); end
    idle();
  endtask

  task automatic test_r0_mask();
    drive(1, 1, 0, 0, 0, 2'b00, 0, 0, 0); #4;
    n_cmp++; if (iss_fire !== 1'b1) begin n_bad++; $display("FAIL r0_fire: got %b want 1", iss_fire); end
    go();
    n_cmp++; if (pend_vec !== '0 || pend_cnt !== 3'd0) begin n_bad++; $display("FAIL r0_untracked: got %h/%0d want 0/0", pend_vec, pend_cnt); end
    drive(1, 1, 7, 0, 0, 2'b00, 0, 0, 0); go();
    drive(1, 0, 0, 2, 7, 2'b01, 0, 0, 0); #4;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mask_src1: got %b want 0", stall); end
    go();
    drive(1, 0, 0, 2, 7, 2'b10, 0, 0, 0); #4;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL unmask_src1: got %b want 1", stall); end
    go();
    drive(0, 0, 0, 0, 0, 2'b00, 1, 7, 0); go();
    idle();
  endtask

  task automatic test_waw();
    drive(1, 1, 3, 0, 0, 2'b00, 0, 0, 0); go();
    drive(1, 1, 3, 0, 0, 2'b00, 0, 0, 0); #4;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_stall: got %b want 1", stall); end
    go();
    drive(1, 1, 3, 0, 0, 2'b00, 1, 3, 0); #4;
    n_cmp++; if (iss_fire !== 1'b1) begin n_bad++; $display("FAIL waw_release: got %b want 1", iss_fire); end
    go();
    n_cmp++; if (pend_vec !== 32'h8 || pend_cnt !== 3'd1) begin n_bad++; $display("FAIL waw_set_wins: got %h/%0d want 8/1", pend_vec, pend_cnt); end
    drive(0, 0, 0, 0, 0, 2'b00, 1, 3, 0); go();
    idle();
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin drive(1, 1, r, 0, 0, 2'b00, 0, 0, 0); go(); end
    n_cmp++; if (pend_cnt !== 3'd4) begin n_bad++; $display("FAIL cap_fill: got %0d want 4", pend_cnt); end
    drive(1, 1, 9, 0, 0, 2'b00, 0, 0, 0); #4;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL cap_stall: got %b want 1", stall); end
    go();
    drive(1, 1, 9, 0, 0, 2'b00, 1, 1, 0); #4;
    n_cmp++; if (iss_fire !== 1'b1) begin n_bad++; $display("FAIL cap_release: got %b want 1", iss_fire); end
    go();
    n_cmp++; if (pend_vec !== 32'h21C || pend_cnt !== 3'd4) begin n_bad++; $display("FAIL cap_after: got %h/%0d want 21c/4", pend_vec, pend_cnt); end
    foreach (mpend[r]) if (mpend[r]) begin drive(0, 0, 0, 0, 0, 2'b00, 1, r, 0); go(); end
    idle();
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin drive(1, 1, r, 0, 0, 2'b00, 0, 0, 0); go(); end
    drive(1, 0, 0, 2, 0, 2'b01, 0, 0, 0); #4;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_pre_stall: got %b want 1", stall); end
    go();
    drive(1, 1, 6, 2, 0, 2'b01, 0, 0, 1); #4;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall); end
    go();
    n_cmp++; if (pend_vec !== '0 || pend_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_clear: got %h/%0d want 0/0", pend_vec, pend_cnt); end
    idle();
  endtask

  task automatic test_async_reset();
    drive(1, 1, 10, 0, 0, 2'b00, 0, 0, 0); go();
    drive(1, 1, 11, 0, 0, 2'b00, 0, 0, 0); go();
    n_cmp++; if (pend_cnt !== 3'd2) begin n_bad++; $display("FAIL areset_pre: got %0d want 2", pend_cnt); end
    drive(1, 0, 0, 10, 11, 2'b11, 0, 0, 0);
    #2 resetn = 1'b0; m_clear();
    #1;
    n_cmp++; if (pend_vec !== '0 || pend_cnt !== 3'd0) begin n_bad++; $display("FAIL areset_clear: got %h/%0d want 0/0", pend_vec, pend_cnt); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL areset_stall: got %b want 0", stall); end
    idle();
    #2 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int pl[$];
    for (int cyc = 0; cyc < 800; cyc++) begin
      pl.delete();
      foreach (mpend[r]) if (mpend[r]) pl.push_back(r);
      iss_valid  = ($urandom_range(0, 3) != 0);
      iss_load   = $urandom_range(0, 1) != 0;
      iss_src_en = NRD'($urandom_range(0, 3));
      for (int k = 0; k < NRD; k++)
        iss_src[k*AW +: AW] = (pl.size() > 0 && $urandom_range(0, 1) != 0) ?
                              AW'(pl[$urandom_range(0, pl.size() - 1)]) : AW'($urandom_range(0, NREG - 1));
      iss_dest = (pl.size() > 0 && $urandom_range(0, 3) == 0) ?
                 AW'(pl[$urandom_range(0, pl.size() - 1)]) : AW'($urandom_range(0, NREG - 1));
      flush    = ($urandom_range(0, 39) == 0);
      wb_valid = !flush && pl.size() > 0 && $urandom_range(0, 2) == 0;
      wb_dest  = wb_valid ? AW'(pl[$urandom_range(0, pl.size() - 1)]) : '0;
      #4;
      n_cmp++; if (stall !== m_stall()) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, stall, m_stall()); end
      n_cmp++; if (iss_fire !== (iss_valid && !m_stall())) begin n_bad++; $display("FAIL rnd_fire c%0d: got %b", cyc, iss_fire); end
      go();
      n_cmp++; if (pend_vec !== m_vec()) begin n_bad++; $display("FAIL rnd_vec c%0d: got %h want %h", cyc, pend_vec, m_vec()); end
      n_cmp++; if (pend_cnt !== CW'(m_count())) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, pend_cnt, m_count()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_raw();
    test_r0_mask();
    test_waw();
    test_capacity();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
